// File: rtl/adder_sub_pkg.sv
// Shared definitions for the adder/subtractor datapath and its result buffer.
package adder_sub_pkg;

  // Op tag carried alongside every result.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Width of the saturating drop counter.
  localparam int DROP_CNT_W = 8;

endpackage

// File: rtl/adder_sub_result_mem.sv
// Storage array for the result buffer: one synchronous write port and one
// asynchronous read port. The array is not reset; validity is tracked by the
// pointers in the parent.
module adder_sub_result_mem #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the addressed entry on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/adder_sub_result_buffer.sv
// Result buffer behind the adder/subtractor: stores {op tag, result} in a
// first-word-fall-through FIFO and hands entries to the consumer.
//
// Handshake: out_valid/out_ready follow strict valid/ready semantics. An entry
// is transferred on a rising edge where out_valid and out_ready are both high;
// out_valid never depends combinationally on out_ready or in_valid, and once
// raised it stays high with stable out_data/out_ctrl until that transfer (or
// a reset/clear). The producer side has no backpressure: in_valid is a strobe,
// and a result arriving while the buffer is full with no same-cycle pop is
// dropped and counted.
module adder_sub_result_buffer
  import adder_sub_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic                    in_ctrl,
  input  logic [DATA_WIDTH:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_ctrl,
  output logic [DATA_WIDTH:0]     out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic [DROP_CNT_W-1:0]   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = DATA_WIDTH + 2;
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {AW{1'b0}}};
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic    pop;
  logic    push;
  logic    drop;
  logic    mem_we;
  op_e     in_op;
  logic [MW-1:0] mem_wdata;
  logic [MW-1:0] mem_rdata;

  // Occupancy flags come straight from the extended pointers.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign out_valid = !empty;
  assign drop_cnt  = drop_cnt_q;

  // A pop while full frees a slot, so a same-cycle push is still accepted.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (!full | pop);
  assign drop = in_valid & full & !pop;

  // A clear discards any push of the same cycle, so keep it out of the array.
  assign mem_we    = push & !clr;
  assign in_op     = op_e'(in_ctrl);
  assign mem_wdata = {in_op, in_data};

  adder_sub_result_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  // Head entry falls through directly; forced to zero while nothing is held.
  always_comb begin
    out_data = '0;
    out_ctrl = 1'b0;
    if (!empty) begin
      out_data = mem_rdata[DATA_WIDTH:0];
      out_ctrl = mem_rdata[DATA_WIDTH+1];
    end
  end

  // Next-state for pointers and drop counter; clear overrides everything.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_cnt_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (drop && (drop_cnt_q != DROP_MAX)) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
